// File: rtl/tile_pkg.sv
// Shared definitions for the tile-matching game: RAM geometry, colour field
// location, controller states and the colour comparison helper.
package tile_pkg;

  localparam int NUM_TILES = 16;
  localparam int TILE_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int COLOR_MSB = 7;
  localparam int COLOR_LSB = 2;
  localparam int NUM_PAIRS = 8;

  localparam logic [TILE_W-1:0] COLOR_MASK =
    TILE_W'((1 << (COLOR_MSB + 1)) - (1 << COLOR_LSB));

  typedef enum logic [3:0] {
    WAIT_A, RD_A, CAP_A, WAIT_B, RD_B, CAP_B, CMP, SHOW, CLR_A, CLR_B, DONE
  } state_t;

  // Two tiles match when their colour fields agree; the low shade bits are cosmetic.
  function automatic logic colorsEqual(input logic [TILE_W-1:0] a,
                                       input logic [TILE_W-1:0] b);
    return ((a ^ b) & COLOR_MASK) == '0;
  endfunction

endpackage

// File: rtl/show_timer.sv
// Loadable down-counter that holds a mismatched pair face-up; zero flags expiry.
module show_timer #(
  parameter int SHOW_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= CNT_W'(SHOW_CYCLES - 1);
    else if (en && !zero)
      count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/match_controller.sv
// Game-sequencing controller: accepts two tile selections, compares their colours
// through the tile RAM port, clears matched pairs and hides mismatched ones.
module match_controller
  import tile_pkg::*;
#(
  parameter int                SHOW_CYCLES = 25_000_000,
  parameter logic [TILE_W-1:0] CLEAR_COLOR = 8'b00000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [ADDR_W-1:0]    selAddr,
  output logic                 ready,
  output logic [ADDR_W-1:0]    ramAddr,
  output logic [TILE_W-1:0]    ramWrite,
  output logic                 ramWe,
  input  logic [TILE_W-1:0]    ramRead,
  output logic [NUM_TILES-1:0] faceUp,
  output logic [NUM_TILES-1:0] matched,
  output logic [3:0]           pairs,
  output logic [7:0]           moves,
  output logic                 matchPulse,
  output logic                 missPulse,
  output logic                 gameOver
);

  state_t              state, nextState;
  logic [ADDR_W-1:0]   tileA, tileB;
  logic [TILE_W-1:0]   byteA, byteB;
  logic                accept, timerLoad, timerZero, clearing;

  show_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timerLoad),
    .en    (state == SHOW),
    .zero  (timerZero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      WAIT_A: if (accept) nextState = RD_A;
      RD_A:   nextState = CAP_A;
      CAP_A:  nextState = WAIT_B;
      WAIT_B: if (accept) nextState = RD_B;
      RD_B:   nextState = CAP_B;
      CAP_B:  nextState = CMP;
      CMP:    nextState = colorsEqual(byteA, byteB) ? CLR_A : SHOW;
      SHOW:   if (timerZero) nextState = WAIT_A;
      CLR_A:  nextState = CLR_B;
      CLR_B:  nextState = (pairs == 4'(NUM_PAIRS - 1)) ? DONE : WAIT_A;
      DONE:   nextState = DONE;
      default: nextState = WAIT_A;
    endcase
  end

  always_comb begin
    ready     = (state == WAIT_A) || (state == WAIT_B);
    gameOver  = (state == DONE);
    timerLoad = (state == CMP) && !colorsEqual(byteA, byteB);
  end

  assign accept   = sel && ready && !matched[selAddr] && !faceUp[selAddr];
  assign clearing = (nextState == CLR_A) || (nextState == CLR_B);

  // RAM port and scoreboard registers; RAM outputs are set up one edge ahead of their state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramAddr    <= '0;
      ramWrite   <= '0;
      ramWe      <= 1'b0;
      faceUp     <= '0;
      matched    <= '0;
      pairs      <= '0;
      moves      <= '0;
      matchPulse <= 1'b0;
      missPulse  <= 1'b0;
      tileA      <= '0;
      tileB      <= '0;
      byteA      <= '0;
      byteB      <= '0;
    end else begin
      matchPulse <= 1'b0;
      missPulse  <= 1'b0;
      ramWe      <= clearing;
      ramWrite   <= clearing ? CLEAR_COLOR : '0;
      if (nextState == CLR_A)      ramAddr <= tileA;
      else if (nextState == CLR_B) ramAddr <= tileB;
      else if (accept)             ramAddr <= selAddr;

      if (accept) begin
        faceUp[selAddr] <= 1'b1;
        if (state == WAIT_A) begin
          tileA <= selAddr;
        end else begin
          tileB <= selAddr;
          if (moves != 8'hFF) moves <= moves + 8'd1;
        end
      end

      if (state == CAP_A) byteA <= ramRead;
      if (state == CAP_B) byteB <= ramRead;

      if (state == SHOW && timerZero) begin
        faceUp[tileA] <= 1'b0;
        faceUp[tileB] <= 1'b0;
        missPulse     <= 1'b1;
      end

      if (state == CLR_B) begin
        matched[tileA] <= 1'b1;
        matched[tileB] <= 1'b1;
        faceUp[tileA]  <= 1'b0;
        faceUp[tileB]  <= 1'b0;
        pairs          <= pairs + 4'd1;
        matchPulse     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a behavioural 16x8 tile RAM.
module tb_match_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  selAddr = '0;
  logic        ready;
  logic [3:0]  ramAddr;
  logic [7:0]  ramWrite;
  logic        ramWe;
  logic [7:0]  ramRead = '0;
  logic [15:0] faceUp, matched;
  logic [3:0]  pairs;
  logic [7:0]  moves;
  logic        matchPulse, missPulse, gameOver;

  logic [7:0]  mem [16];
  int          passed = 0;
  int          total = 0;

  match_controller #(.SHOW_CYCLES(4), .CLEAR_COLOR(8'h00)) dut (
    .clk(clk), .reset(reset), .sel(sel), .selAddr(selAddr), .ready(ready),
    .ramAddr(ramAddr), .ramWrite(ramWrite), .ramWe(ramWe), .ramRead(ramRead),
    .faceUp(faceUp), .matched(matched), .pairs(pairs), .moves(moves),
    .matchPulse(matchPulse), .missPulse(missPulse), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWrite;
    ramRead <= mem[ramAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic selectTile(input logic [3:0] a);
    sel = 1'b1;
    selAddr = a;
    tick();
    sel = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ramAddr"}, ramAddr, 0);
    check({tag, "_ramWrite"}, ramWrite, 0);
    check({tag, "_ramWe"}, ramWe, 0);
    check({tag, "_faceUp"}, faceUp, 0);
    check({tag, "_matched"}, matched, 0);
    check({tag, "_pairs"}, pairs, 0);
    check({tag, "_moves"}, moves, 0);
    check({tag, "_pulses"}, {matchPulse, missPulse}, 0);
    check({tag, "_gameOver"}, gameOver, 0);
    check({tag, "_ready"}, ready, 1);
  endtask

  logic [3:0] pa [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13};
  logic [3:0] pb [8] = '{4'd14, 4'd4, 4'd3, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15};

  initial begin
    mem[0]  = 8'h3F; mem[14] = 8'h3E;
    mem[2]  = 8'hE3; mem[3]  = 8'hE3;
    mem[1]  = 8'h40; mem[4]  = 8'h40;
    mem[5]  = 8'h44; mem[6]  = 8'h47;
    mem[7]  = 8'h80; mem[8]  = 8'h80;
    mem[9]  = 8'h84; mem[10] = 8'h84;
    mem[11] = 8'hC0; mem[12] = 8'hC0;
    mem[13] = 8'hC4; mem[15] = 8'hC4;

    // Run 1: reset state, then match 2/3
    tick(2);
    reset = 1'b0;
    checkAllZero("reset");
    selectTile(4'd2);
    check("acceptA_faceUp", faceUp, 16'h0004);
    check("acceptA_ramAddr", ramAddr, 4'd2);
    check("acceptA_ready", ready, 0);
    tick(2);
    check("waitB_ready", ready, 1);
    selectTile(4'd3);
    check("acceptB_moves", moves, 1);
    check("acceptB_faceUp", faceUp, 16'h000C);
    tick(3);
    check("clrA_we", ramWe, 1);
    check("clrA_addr", ramAddr, 4'd2);
    check("clrA_data", ramWrite, 8'h00);
    check("clrA_pulse", matchPulse, 0);
    tick();
    check("clrB_addr", ramAddr, 4'd3);
    check("clrB_we", ramWe, 1);
    tick();
    check("match_pulse", matchPulse, 1);
    check("match_matched", matched, 16'h000C);
    check("match_pairs", pairs, 1);
    check("match_faceUp", faceUp, 0);
    check("match_we_off", ramWe, 0);
    check("ram2_cleared", mem[2], 8'h00);
    check("ram3_cleared", mem[3], 8'h00);
    tick();
    check("match_pulse_width", matchPulse, 0);
    check("match_moves", moves, 1);

    // Run 2: miss 0/1, shade-insensitive match 0/14, rejects in WAIT_B
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rerun_ram2_kept", mem[2], 8'h00);
    selectTile(4'd0);
    tick(2);
    selectTile(4'd1);
    check("miss_moves", moves, 1);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("show_faceUp_%0d", i), faceUp, 16'h0003);
      check($sformatf("show_noMiss_%0d", i), missPulse, 0);
      tick();
    end
    check("miss_faceUp_cleared", faceUp, 0);
    check("miss_pulse", missPulse, 1);
    check("miss_pairs", pairs, 0);
    check("miss_moves_after", moves, 1);
    tick();
    check("miss_pulse_width", missPulse, 0);
    check("miss_ready", ready, 1);

    selectTile(4'd0);
    tick(2);
    selectTile(4'd14);
    tick(5);
    check("shade_match_pulse", matchPulse, 1);
    check("shade_match_matched", matched, 16'h4001);
    tick();

    selectTile(4'd4);
    tick(2);
    selectTile(4'd4);
    check("reselA_ready", ready, 1);
    check("reselA_moves", moves, 2);
    check("reselA_faceUp", faceUp, 16'h0010);
    selectTile(4'd0);
    check("selMatched_ready", ready, 1);
    check("selMatched_moves", moves, 2);
    selectTile(4'd1);
    check("afterReject_moves", moves, 3);
    tick(5);
    check("match14_matched", matched, 16'h4013);
    check("match14_pairs", pairs, 2);
    tick();

    // sel held through SHOW is dropped, then reset mid-SHOW
    selectTile(4'd5);
    tick(2);
    selectTile(4'd7);
    tick(3);
    sel = 1'b1;
    selAddr = 4'd9;
    tick(2);
    check("showSel_ready", ready, 0);
    check("showSel_faceUp", faceUp, 16'h00A0);
    sel = 1'b0;
    reset = 1'b1;
    tick();
    checkAllZero("midShowReset");
    reset = 1'b0;

    // Run 3: full game to gameOver
    for (int k = 0; k < 8; k++) begin
      selectTile(pa[k]);
      tick(2);
      selectTile(pb[k]);
      tick(5);
      check($sformatf("game_pulse_%0d", k), matchPulse, 1);
      check($sformatf("game_pairs_%0d", k), pairs, k + 1);
      tick();
    end
    check("game_matched", matched, 16'hFFFF);
    check("game_over", gameOver, 1);
    check("game_moves", moves, 8);
    check("game_ready", ready, 0);
    selectTile(4'd3);
    tick(3);
    check("done_sel_faceUp", faceUp, 0);
    check("done_sel_moves", moves, 8);
    check("done_held", gameOver, 1);
    check("done_we", ramWe, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/match_controller.md
# match_controller

Game-sequencing controller for the 16-entry, 8-bit tile RAM of the tile-matching game. It owns one RAM port (address, write data, write enable, registered read data). It accepts player tile selections and reads the two selected tiles' colours. On a match it overwrites both tiles with the cleared colour; on a miss it leaves them shown for a fixed time and then hides them. Score, move count and per-tile visibility flags go to the VGA/renderer and the seven-segment display logic.

## Interface
Parameters:
- SHOW_CYCLES, 25_000_000: cycles a mismatched pair stays face-up (0.5 s at 50 MHz); must be ≥ 1.
- CLEAR_COLOR, 8'b00000000: value written to matched tiles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  one-cycle selection strobe.
- selAddr  in  4  tile index for sel.
- ready  out  1  high when a sel will be evaluated this cycle.
- ramAddr  out  4  tile RAM address (registered).
- ramWrite  out  8  tile RAM write data (registered).
- ramWe  out  1  tile RAM write enable (registered).
- ramRead  in  8  tile RAM read data; valid one cycle after RAM samples ramAddr.
- faceUp  out  16  bit i = tile i currently shown.
- matched  out  16  bit i = tile i cleared.
- pairs  out  4  matched pair count, 0..8.
- moves  out  8  completed pair attempts, saturates at 255.
- matchPulse  out  1  one-cycle pulse per match.
- missPulse  out  1  one-cycle pulse when a mismatched pair is hidden.
- gameOver  out  1  high once pairs = 8, held until reset.

## Operation
- Colour field is bits [7:2]. Bits [1:0] are ignored in comparison.
- States: WAIT_A, RD_A, CAP_A, WAIT_B, RD_B, CAP_B, CMP, SHOW, CLR_A, CLR_B, DONE.
- ready = 1 only in WAIT_A and WAIT_B.
- WAIT_A: accepts sel if selAddr is neither matched nor faceUp.
  - On accept: latch tileA, set ramAddr = selAddr, set faceUp[selAddr], go to RD_A.
  - Invalid selections are ignored; no flag changes.
- RD_A → CAP_A unconditionally (RAM sampling cycle).
- CAP_A: capture colourA = ramRead[7:2], go to WAIT_B.
- WAIT_B: same accept rule as WAIT_A. Selecting tileA again is rejected because it is faceUp.
  - On accept: latch tileB, set ramAddr, set faceUp bit, increment moves (saturating), go to RD_B.
- RD_B → CAP_B. CAP_B captures colourB and goes to CMP.
- CMP, colours equal: go to CLR_A.
- CMP, colours differ: load the counter with SHOW_CYCLES−1 and go to SHOW.
- SHOW: decrement each cycle. At 0: clear faceUp[tileA] and faceUp[tileB], pulse missPulse, go to WAIT_A.
- CLR_A: ramAddr = tileA, ramWrite = CLEAR_COLOR, ramWe = 1.
- CLR_B: same for tileB. On exit:
  - set matched[tileA] and matched[tileB];
  - clear their faceUp bits;
  - increment pairs and pulse matchPulse;
  - go to DONE if the new pairs = 8, else WAIT_A.
- ramWe is 1 only during CLR_A and CLR_B.
- DONE: gameOver = 1; sel ignored; left only by reset.
- sel while not ready is dropped, not queued.
- Reset, including mid-SHOW or mid-CLR:
  - state = WAIT_A;
  - all outputs 0 (ramAddr, ramWrite, ramWe, faceUp, matched, pairs, moves, pulses, gameOver);
  - counter = 0.
  - RAM contents are not restored; a tile already cleared stays CLEAR_COLOR.

## Timing
- sel accepted at edge E0: faceUp bit visible after E0; ramAddr valid after E0.
- RAM samples at E1; the colour is captured at E2; ready is reasserted after E2 (WAIT_B).
- Second selection at edge F0 → CMP after F2 → decision at F3.
- Match: writes occur in the two cycles after F3; matchPulse and matched bits appear after F5.
- Miss: faceUp cleared exactly SHOW_CYCLES cycles after entering SHOW.
- Pulses are exactly one cycle wide.

## Structure
- Shared package tile_pkg:
  - NUM_TILES = 16, TILE_W = 8, ADDR_W = 4;
  - COLOR_MSB = 7, COLOR_LSB = 2;
  - state enum;
  - NUM_PAIRS = 8.
- One sub-module, show_timer: loadable down-counter sized by $clog2(SHOW_CYCLES), with a zero flag.

## Test plan
(Power-up RAM image: tiles 2/3 both 8'b11100011 orange; tiles 0/14 are 8'b00111111 and 8'b00111110 teal. SHOW_CYCLES = 4 in simulation.)
- Select 2 then 3 → matchPulse once; RAM[2] = RAM[3] = 8'h00; matched = 16'h000C; pairs = 1; moves = 1.
- Select 0 then 14 → match despite bit0 difference; matched bits 0 and 14 set.
- Select 0 then 1 → faceUp = 16'h0003 for exactly 4 SHOW cycles, then 0; missPulse once; pairs unchanged; moves = 1.
- Reselect the first tile, or an already-matched tile, in WAIT_B → ignored, ready stays 1, moves unchanged. sel held during SHOW → dropped.
- Match all 8 pairs → pairs = 8, gameOver = 1; further sel ignored. Assert reset mid-SHOW in a separate run → all outputs 0 next cycle, state WAIT_A.
